pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Pipeline latch sequencer for the 5-stage datapath. It consumes the hazard
//  unit verdicts (hazard/branch/jump) plus the cache handshakes (ihit/dhit).
//  It drives the PC enable and the per-latch enable/flush controls for
//  IF/ID, ID/EX, EX/MEM and MEM/WB.
//  It tracks wrong-path fetch squashes, halt retirement and data-wait
//  timeouts. It sits between the hazard unit and the pipeline registers.
// PARAMETERS
//  CNT_W    32    width of perf counters
//  TIMEOUT  1024  consecutive dstall cycles before dwait_timeout asserts (>=2)
// PORTS
//  CLK            in   1      clock; all state updates on rising edge
//  RST            in   1      synchronous reset, active-high
//  ihit           in   1      instruction word valid for current PC
//  dhit           in   1      data access in MEM completes this cycle
//  mem_dmemREN    in   1      MEM-stage load pending
//  mem_dmemWEN    in   1      MEM-stage store pending
//  hazard         in   1      data hazard in ID: hold IF/ID, bubble EX
//  branch         in   1      taken branch resolved in ID
//  jump           in   1      jump/jr/jal in ID
//  mem_halt       in   1      halt instruction in MEM stage
//  pc_en          out  1      PC register load
//  if_id_en       out  1      IF/ID latch enable
//  if_id_flush    out  1      IF/ID load bubble (valid only with if_id_en)
//  id_ex_en       out  1      ID/EX latch enable
//  id_ex_flush    out  1      ID/EX load bubble
//  ex_mem_en      out  1      EX/MEM latch enable
//  mem_wb_en      out  1      MEM/WB latch enable
//  mem_wb_flush   out  1      MEM/WB load bubble
//  squash_pend    out  1      registered: next ihit word is wrong-path
//  dwait_timeout  out  1      registered, sticky until RST
//  halted         out  1      registered, sticky until RST (state==HALTED)
//  state          out  2      registered FSM: 0 RUN, 1 DWAIT, 2 HALTED
//  stall_cnt      out  CNT_W  PC-stall cycles (PIPE_PERF_EN)
//  flush_cnt      out  CNT_W  cycles with any flush asserted (PIPE_PERF_EN)
// BEHAVIOUR
//  dstall = (mem_dmemREN|mem_dmemWEN) & ~dhit. Controls are combinational,
//  evaluated in this priority order:
//  P0 RST=1 or state==HALTED: every en/flush = 0.
//  P1 dstall: pc_en=0, if_id_en=id_ex_en=ex_mem_en=0;
//     mem_wb_en=1, mem_wb_flush=1 (bubble into WB, no double writeback).
//  P2 otherwise ex_mem_en=1, mem_wb_en=1, mem_wb_flush=0, then:
//   a hazard: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1.
//     branch/jump are ignored this cycle.
//   b branch|jump: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1.
//     If ihit=0, set squash_pend.
//   c squash_pend & ihit: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_en=1.
//     Clear squash_pend.
//   d ihit: pc_en=1, if_id_en=1, id_ex_en=1, no flush.
//   e ~ihit: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_en=1.
//  Any en/flush not listed in a case = 0.
//  FSM next state:
//   HALTED stays HALTED.
//   mem_halt & ~dstall -> HALTED; the halt still retires into WB that cycle.
//   dstall -> DWAIT; else RUN.
//  squash_pend:
//   - holds through P1 and P2a cycles;
//   - a branch|jump with ihit=0 while already set keeps it set;
//   - a branch|jump with ihit=1 clears it.
//  Timeout: wait_cnt counts consecutive cycles with dstall=1 and resets to 0
//   when dstall=0. dwait_timeout sets when wait_cnt reaches TIMEOUT-1 with
//   dstall still 1. The pipeline keeps stalling afterwards (flag only).
//  Reset, next edge after RST=1: state=RUN, squash_pend=0, dwait_timeout=0,
//   halted=0, wait_cnt=0, counters=0. Reset applies mid-stall or in HALTED.
// CONFIGURATION
//  PIPE_PERF_EN defined:
//   - stall_cnt += 1 each cycle with pc_en=0 and state!=HALTED and RST=0.
//   - flush_cnt += 1 each cycle with any flush = 1.
//   - Both saturate at all-ones.
//  PIPE_PERF_EN undefined: counters not built; stall_cnt = flush_cnt = 0.
// TESTING
//  1 RST 1 cycle, ihit=1 steady -> pc_en=if_id_en=id_ex_en=1, state=0, no flush.
//  2 mem_dmemREN=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles pc_en=0,
//    mem_wb_flush=1, state=1; cycle 4 state=0.
//  3 hazard=1 & branch=1, ihit=1 -> pc_en=0, if_id_en=0, id_ex_flush=1.
//    Next cycle hazard=0, branch=1 -> pc_en=1, if_id_flush=1.
//  4 branch=1, ihit=0 -> squash_pend=1. 2 cycles ihit=0, then ihit=1
//    -> that cycle if_id_flush=1, pc_en=0; squash_pend=0 after.
//  5 mem_halt=1, dstall=0 -> mem_wb_en=1 that cycle, then halted=1, all en=0
//    for 10 cycles; RST -> state=0.
//  6 TIMEOUT=4, dhit=0 held -> dwait_timeout=1 after 4th stall cycle, stays 1
//    after dhit; PIPE_PERF_EN: stall_cnt==flush_cnt==stall cycles.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline latch sequencer: turns hazard verdicts and cache handshakes into PC/latch enables and flushes.
// Optional perf counters are built only when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dmemREN,
  input  logic             mem_dmemWEN,
  input  logic             hazard,
  input  logic             branch,
  input  logic             jump,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             squash_pend,
  output logic             dwait_timeout,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int WCW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           squash_d;
  logic [WCW-1:0] wait_cnt;
  logic           dstall;

  assign dstall = (mem_dmemREN | mem_dmemWEN) & ~dhit;
  assign state  = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      halted      <= 1'b0;
      squash_pend <= 1'b0;
    end else begin
      state_q     <= state_d;
      halted      <= (state_d == HALTED);
      squash_pend <= squash_d;
    end
  end

  // Control decode in strict priority order; squash_pend only moves in branch/refetch cases.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    mem_wb_flush = 1'b0;
    squash_d     = squash_pend;
    if (RST || state_q == HALTED) begin
      squash_d = squash_pend;
    end else if (dstall) begin
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (hazard) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
      end else if (branch || jump) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        squash_d    = ~ihit;
      end else if (squash_pend && ihit) begin
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        squash_d    = 1'b0;
      end else if (ihit) begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        id_ex_en = 1'b1;
      end else begin
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = RUN;
    if (state_q == HALTED)          state_d = HALTED;
    else if (mem_halt && !dstall)   state_d = HALTED;
    else if (dstall)                state_d = DWAIT;
    else                            state_d = RUN;
  end

  // wait_cnt parks at TIMEOUT-1; the flag is sticky, the stall itself continues.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt      <= '0;
      dwait_timeout <= 1'b0;
    end else if (dstall) begin
      if (wait_cnt == WAIT_LAST) dwait_timeout <= 1'b1;
      else                       wait_cnt      <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef PIPE_PERF_EN
  logic any_flush;
  assign any_flush = if_id_flush | id_ex_flush | mem_wb_flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && state_q != HALTED && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (any_flush && flush_cnt != '1)                   flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
